// File: rtl/cnn_pkg.sv
// Shared definitions for the window scanner slice.
// Holds the default frame geometry, the scanner FSM state type and the
// 3x3 window container type used by consumers at the default word width.
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_WIDTH      = 13;
  localparam int DEFAULT_HEIGHT     = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } scan_state_e;

  // Nine taps, row-major, index 0 = top-left of the window.
  typedef logic [DEFAULT_DATA_WIDTH-1:0] window_t [0:8];

endpackage

// File: rtl/window_gather.sv
// Combinational 3x3 tap selector.
// Picks the nine words around centre (row, col) out of the frame array.
// Config macro WINDOW_SCANNER_PAD_EN: when defined, taps that fall outside
// the frame read as zero (centres may sit on the frame edge); when
// undefined, centres are guaranteed interior and no range check is built.
// Ports:
//   frame - full frame array [0:HEIGHT-1][0:WIDTH-1]
//   row   - centre row
//   col   - centre column
//   taps  - nine window words, row-major
module window_gather
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT
) (
  input  logic [DATA_WIDTH-1:0]      frame [0:HEIGHT-1][0:WIDTH-1],
  input  logic [$clog2(HEIGHT)-1:0]  row,
  input  logic [$clog2(WIDTH)-1:0]   col,
  output logic [DATA_WIDTH-1:0]      taps  [0:8]
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);

  for (genvar dr = 0; dr < 3; dr++) begin : g_row
    for (genvar dc = 0; dc < 3; dc++) begin : g_col
`ifdef WINDOW_SCANNER_PAD_EN
      // One extra bit so that "centre - 1" at index 0 wraps to a value that
      // is always >= the frame size and is caught by the range check.
      localparam int RX = RW + 1;
      localparam int CX = CW + 1;
      logic [RX-1:0] ri;
      logic [CX-1:0] ci;
      assign ri = {1'b0, row} + RX'(dr) - RX'(1);
      assign ci = {1'b0, col} + CX'(dc) - CX'(1);
      assign taps[dr*3+dc] = (ri >= RX'(HEIGHT) || ci >= CX'(WIDTH))
                             ? {DATA_WIDTH{1'b0}}
                             : frame[ri[RW-1:0]][ci[CW-1:0]];
`else
      logic [RW-1:0] ri;
      logic [CW-1:0] ci;
      assign ri = row + RW'(dr) - RW'(1);
      assign ci = col + CW'(dc) - CW'(1);
      assign taps[dr*3+dc] = frame[ri][ci];
`endif
    end
  end

endmodule

// File: rtl/window_scanner.sv
// Raster-order 3x3 window scanner with valid/ready output handshake.
// A frame_valid pulse in IDLE starts a scan; each accepted window is
// replaced by its raster successor on the next cycle. After the final
// window is accepted the FSM spends one cycle in DONE, then returns to IDLE.
// frame_valid outside IDLE is ignored and reported on frame_drop.
// Config macro WINDOW_SCANNER_PAD_EN: when defined, centres cover the whole
// frame with zero-filled borders; otherwise only interior centres are used.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   frame_valid, frame - frame-complete pulse and frame array
//   win_valid/win_ready- output handshake
//   win_data           - 3x3 window, row-major
//   win_row, win_col   - window centre position
//   win_last           - window is the last of the frame
//   busy               - scan in progress (SCAN or DONE)
//   frame_drop         - one-cycle pulse when frame_valid was ignored
module window_scanner
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_valid,
  input  logic [DATA_WIDTH-1:0]     frame [0:HEIGHT-1][0:WIDTH-1],
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [DATA_WIDTH-1:0]     win_data [0:8],
  output logic [$clog2(HEIGHT)-1:0] win_row,
  output logic [$clog2(WIDTH)-1:0]  win_col,
  output logic                      win_last,
  output logic                      busy,
  output logic                      frame_drop
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);

`ifdef WINDOW_SCANNER_PAD_EN
  localparam logic [RW-1:0] ROW_FIRST = RW'(0);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(0);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
`else
  localparam logic [RW-1:0] ROW_FIRST = RW'(1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 2);
  localparam logic [CW-1:0] COL_FIRST = CW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 2);
`endif

  scan_state_e           state;
  logic [RW-1:0]         nxt_row;
  logic [CW-1:0]         nxt_col;
  logic                  nxt_last;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] taps [0:8];

  assign xfer = win_valid && win_ready;

  // Position of the window to load next: first centre from IDLE, raster
  // successor of the presented window while scanning.
  always_comb begin
    nxt_row = ROW_FIRST;
    nxt_col = COL_FIRST;
    if (state == ST_SCAN) begin
      if (win_col == COL_LAST) begin
        nxt_row = win_row + RW'(1);
        nxt_col = COL_FIRST;
      end else begin
        nxt_row = win_row;
        nxt_col = win_col + CW'(1);
      end
    end else begin
      nxt_row = ROW_FIRST;
      nxt_col = COL_FIRST;
    end
    nxt_last = (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);
  end

  window_gather #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT)
  ) u_gather (
    .frame (frame),
    .row   (nxt_row),
    .col   (nxt_col),
    .taps  (taps)
  );

  // Scan FSM and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_last   <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
      for (int k = 0; k < 9; k++) win_data[k] <= '0;
    end else begin
      frame_drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_valid) begin
            state     <= ST_SCAN;
            busy      <= 1'b1;
            win_valid <= 1'b1;
            win_row   <= nxt_row;
            win_col   <= nxt_col;
            win_last  <= nxt_last;
            for (int k = 0; k < 9; k++) win_data[k] <= taps[k];
          end
        end
        ST_SCAN: begin
          frame_drop <= frame_valid;
          if (xfer) begin
            if (win_last) begin
              state     <= ST_DONE;
              win_valid <= 1'b0;
            end else begin
              win_row  <= nxt_row;
              win_col  <= nxt_col;
              win_last <= nxt_last;
              for (int k = 0; k < 9; k++) win_data[k] <= taps[k];
            end
          end
        end
        ST_DONE: begin
          // A frame_valid here is dropped: IDLE is the only accept state.
          frame_drop <= frame_valid;
          state      <= ST_IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          win_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_scanner.sv
// Directed self-checking bench for window_scanner at default geometry.
// Frame word at (r, c) is r*16 + c, so every expected tap is computed
// directly from its position. Honours WINDOW_SCANNER_PAD_EN if defined.
module tb_window_scanner;
  import cnn_pkg::*;

  localparam int DW = 32;
  localparam int W  = 13;
  localparam int H  = 17;
`ifdef WINDOW_SCANNER_PAD_EN
  localparam int RF = 0, RL = H - 1, CF = 0, CL = W - 1;
`else
  localparam int RF = 1, RL = H - 2, CF = 1, CL = W - 2;
`endif
  localparam int NWIN = (RL - RF + 1) * (CL - CF + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_valid;
  logic [DW-1:0] frame [0:H-1][0:W-1];
  logic          win_valid;
  logic          win_ready;
  window_t       win_data;
  logic [4:0]    win_row;
  logic [3:0]    win_col;
  logic          win_last;
  logic          busy;
  logic          frame_drop;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  window_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame       (frame),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_data    (win_data),
    .win_row     (win_row),
    .win_col     (win_col),
    .win_last    (win_last),
    .busy        (busy),
    .frame_drop  (frame_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_tap(input int r, input int c, input int k);
    int rr;
    int cc;
    rr = r + k / 3 - 1;
    cc = c + k % 3 - 1;
    if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 32'h0000_0000;
    return 32'(rr * 16 + cc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_win(input int r, input int c, input string tag);
    chk({tag, ".valid"}, 64'(win_valid), 64'd1);
    chk({tag, ".row"}, 64'(win_row), 64'(r));
    chk({tag, ".col"}, 64'(win_col), 64'(c));
    chk({tag, ".last"}, 64'(win_last), 64'((r == RL && c == CL) ? 1 : 0));
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s.tap%0d", tag, k), 64'(win_data[k]), 64'(exp_tap(r, c, k)));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 64'(win_valid), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".row"}, 64'(win_row), 64'd0);
    chk({tag, ".col"}, 64'(win_col), 64'd0);
    chk({tag, ".last"}, 64'(win_last), 64'd0);
    chk({tag, ".drop"}, 64'(frame_drop), 64'd0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s.tap%0d", tag, k), 64'(win_data[k]), 64'd0);
  endtask

  task automatic adv(inout int r, inout int c);
    if (c == CL) begin
      c = CF;
      r = r + 1;
    end else begin
      c = c + 1;
    end
  endtask

  // Consume windows with win_ready held high, checking each one; optionally
  // pulse frame_valid while window drop_at is presented.
  task automatic scan_run(input int drop_at, input int stop_at, output int drops);
    int r;
    int c;
    r = RF;
    c = CF;
    drops = 0;
    for (int n = 0; n < stop_at; n++) begin
      chk_win(r, c, $sformatf("scan_w%0d", n));
      if (frame_drop === 1'b1) drops++;
      frame_valid = (n == drop_at);
      tick();
      frame_valid = 1'b0;
      adv(r, c);
    end
  endtask

  initial begin
    int drops;
    int r;
    int c;
    int n;
    int cyc;

    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        frame[i][j] = 32'(i * 16 + j);

    // Reset state
    rst = 1'b1;
    frame_valid = 1'b0;
    win_ready = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;

    // Ready with nothing valid has no effect
    win_ready = 1'b1;
    tick();
    chk("idle_ready.valid", 64'(win_valid), 64'd0);
    chk("idle_ready.busy", 64'(busy), 64'd0);

    // Full scan, ready always high
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("scan1.busy", 64'(busy), 64'd1);
    scan_run(-1, NWIN, drops);
    chk("scan1.drops", 64'(drops), 64'd0);
    chk("done.valid", 64'(win_valid), 64'd0);
    chk("done.busy", 64'(busy), 64'd1);
    // frame_valid during DONE is dropped, not accepted
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("done_fv.drop", 64'(frame_drop), 64'd1);
    chk("done_fv.busy", 64'(busy), 64'd0);
    chk("done_fv.valid", 64'(win_valid), 64'd0);
    tick();
    chk("after_done.valid", 64'(win_valid), 64'd0);
    chk("after_done.drop", 64'(frame_drop), 64'd0);
    chk("after_done.busy", 64'(busy), 64'd0);

    // Scan with a stray frame_valid at window 50
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    scan_run(50, NWIN, drops);
    chk("scan2.drops", 64'(drops), 64'd1);
    chk("scan2.end_valid", 64'(win_valid), 64'd0);
    tick();

    // Scan with pseudo-random back-pressure
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    r = RF;
    c = CF;
    n = 0;
    cyc = 0;
    while (n < NWIN && cyc < 20000) begin
      chk_win(r, c, $sformatf("stall_w%0d", n));
      win_ready = 1'($urandom_range(0, 1));
      tick();
      if (win_ready) begin
        n++;
        adv(r, c);
      end
      cyc++;
    end
    chk("stall.count", 64'(n), 64'(NWIN));
    win_ready = 1'b1;
    chk("stall.end_valid", 64'(win_valid), 64'd0);
    tick();

    // Reset in the middle of a scan, with frame_valid in the same cycle
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    scan_run(-1, 80, drops);
    rst = 1'b1;
    frame_valid = 1'b1;
    tick();
    rst = 1'b0;
    frame_valid = 1'b0;
    chk_reset("midrst");
    tick();
    chk("midrst_fv.valid", 64'(win_valid), 64'd0);
    chk("midrst_fv.busy", 64'(busy), 64'd0);

    // Restart after reset begins at the first centre
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    scan_run(-1, NWIN, drops);
    chk("restart.drops", 64'(drops), 64'd0);
    chk("restart.end_valid", 64'(win_valid), 64'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/window_scanner.md
WINDOW_SCANNER -- requirements
Module: window_scanner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width (FP32 bit pattern, passed through untouched).
REQ-002 SHALL have parameter WIDTH, default 13, frame columns.
REQ-003 SHALL have parameter HEIGHT, default 17, frame rows.
REQ-004 SHALL have port clk  input  1  sole clock; one clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port frame_valid  input  1  one-cycle pulse: frame complete and stable.
REQ-007 SHALL have port frame  input  DATA_WIDTH x [0:HEIGHT-1][0:WIDTH-1]  one channel's frame array.
REQ-008 SHALL have port win_valid  output  1  window available.
REQ-009 SHALL have port win_ready  input  1  consumer accepts window.
REQ-010 SHALL have port win_data  output  DATA_WIDTH x [0:8]  3x3 window, row-major, index 0 = top-left.
REQ-011 SHALL have port win_row  output  $clog2(HEIGHT)  window centre row.
REQ-012 SHALL have port win_col  output  $clog2(WIDTH)  window centre column.
REQ-013 SHALL have port win_last  output  1  current window is the frame's final window.
REQ-014 SHALL have port busy  output  1  scan in progress.
REQ-015 SHALL have port frame_drop  output  1  one-cycle pulse: frame_valid ignored while busy.

Function
REQ-016 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE; busy=1 in SCAN and DONE.
REQ-017 IDLE: frame_valid at cycle t SHALL load first window (centre row 1, col 1) and raise win_valid at t+1.
REQ-018 SCAN: a transfer occurs on win_valid && win_ready; next cycle SHALL present the next raster-order window (col increments; at last col, col resets and row increments).
REQ-019 win_data, win_row, win_col, win_last SHALL be registered and held stable while win_valid && !win_ready.
REQ-020 Without padding, centres SHALL span rows 1..HEIGHT-2, cols 1..WIDTH-2: 165 windows at defaults.
REQ-021 Transfer of the window with win_last=1 SHALL go to DONE, drop win_valid next cycle; DONE lasts exactly one cycle, then IDLE.
REQ-022 frame_valid in SCAN or DONE SHALL be ignored and pulse frame_drop for one cycle; scan unaffected.
REQ-023 frame_valid coincident with DONE SHALL be dropped (no back-to-back acceptance); IDLE is the only accept state.
REQ-024 frame SHALL be sampled combinationally at each window load; upstream holds it stable while busy.
REQ-025 win_ready high while win_valid low SHALL have no effect.

Reset
REQ-026 rst=1 at any edge, including mid-scan, SHALL force IDLE, win_valid=0, win_data all zero, win_row=0, win_col=0, win_last=0, busy=0, frame_drop=0.
REQ-027 frame_valid asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-028 Macro WINDOW_SCANNER_PAD_EN defined: centres SHALL span all rows 0..HEIGHT-1 and cols 0..WIDTH-1 (221 windows at defaults); out-of-frame taps SHALL read 32'h0000_0000.
REQ-029 Macro undefined: no padding logic compiled; behaviour per REQ-020.

Structure
REQ-030 Package cnn_pkg SHALL hold DATA_WIDTH/WIDTH/HEIGHT defaults, the FSM state enum, and window typedef (9 x DATA_WIDTH).
REQ-031 Combinational sub-module window_gather SHALL produce 9 taps from frame, row, col (with zero-fill under WINDOW_SCANNER_PAD_EN); counters, FSM, output registers stay in window_scanner.

Verification
REQ-032 frame[r][c]=r*16+c, win_ready=1, pulse frame_valid -> 165 windows on consecutive cycles, first win_data = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22}, last centre (15,11), win_last only on it.
REQ-033 win_ready toggled pseudo-randomly -> no window lost or repeated; outputs stable across every stall cycle.
REQ-034 frame_valid pulsed at window 50 -> frame_drop pulses once, scan completes all 165 windows unchanged.
REQ-035 rst pulsed at window 80 -> next cycle all outputs zero, IDLE; subsequent frame_valid restarts at centre (1,1).
REQ-036 With WINDOW_SCANNER_PAD_EN, same frame -> 221 windows; first win_data = {0,0,0,0,0x00,0x01,0,0x10,0x11}; last centre (16,12) with right/bottom taps zero.
